// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared widths, op encodings and FSM states for the multiply/divide unit
package muldiv_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = $clog2(DATA_W);

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MULHU = 2'b01,
    OP_DIVU  = 2'b10,
    OP_REMU  = 2'b11
  } opCode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Division ops share the restoring-divide datapath mode
  function automatic logic isDivOp(input opCode_t op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  // MULHU and REMU both take their result from the upper half of the accumulator
  function automatic logic selectsHigh(input opCode_t op);
    return (op == OP_MULHU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - issue and write-back signals between execute stage and multiply/divide unit
interface muldiv_unit_if;
  import muldiv_pkg::*;

  logic                start_valid;
  logic                start_ready;
  opCode_t             op;
  logic [DATA_W-1:0]   rs1_data;
  logic [DATA_W-1:0]   rs2_data;
  logic [REG_AW-1:0]   rd;
  logic                flush;
  logic                busy;
  logic [REG_AW-1:0]   busy_rd;
  logic                wb_valid;
  logic                wb_ready;
  logic [REG_AW-1:0]   wb_reg;
  logic [DATA_W-1:0]   wb_data;

  // Execute stage side: issues operations and accepts write-back results
  modport master (
    output start_valid, op, rs1_data, rs2_data, rd, flush, wb_ready,
    input  start_ready, busy, busy_rd, wb_valid, wb_reg, wb_data
  );

  // Multiply/divide unit side
  modport slave (
    input  start_valid, op, rs1_data, rs2_data, rd, flush, wb_ready,
    output start_ready, busy, busy_rd, wb_valid, wb_reg, wb_data
  );

endinterface

// File: rtl/muldiv_datapath.sv
// rtl/muldiv_datapath.sv - shift-add multiply / restoring divide accumulator, one bit per step
module muldiv_datapath
  import muldiv_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  opCode_t           op,
  input  logic [DATA_W-1:0] opA,
  input  logic [DATA_W-1:0] opB,
  output logic [DATA_W-1:0] result_lo,
  output logic [DATA_W-1:0] result_hi
);

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  // Divide:   acc = {partial remainder, remaining dividend / growing quotient}, shifted left.
  logic [2*DATA_W-1:0] acc;
  logic [2*DATA_W-1:0] accNext;
  logic [DATA_W-1:0]   operand;
  logic                divMode;

  logic [DATA_W:0]     mulSum;
  logic [DATA_W:0]     divUpper;
  logic [DATA_W-1:0]   divDiff;
  logic                divFits;

  // One iteration: conditional add for multiply, trial subtract for divide
  always_comb begin
    mulSum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, operand} : '0);
    divUpper = acc[2*DATA_W-1:DATA_W-1];
    divDiff  = divUpper[DATA_W-1:0] - operand;
    divFits  = divUpper[DATA_W] | (divUpper[DATA_W-1:0] >= operand);
    if (divMode) begin
      // A zero divisor always "fits": quotient fills with ones, remainder collects the dividend
      accNext = {(divFits ? divDiff : divUpper[DATA_W-1:0]), acc[DATA_W-2:0], divFits};
    end else begin
      accNext = {mulSum, acc[DATA_W-1:1]};
    end
  end

  // Operand capture on load, one iteration per step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      operand <= '0;
      divMode <= 1'b0;
    end else if (load) begin
      acc     <= {{DATA_W{1'b0}}, (isDivOp(op) ? opA : opB)};
      operand <= isDivOp(op) ? opB : opA;
      divMode <= isDivOp(op);
    end else if (step) begin
      acc <= accNext;
    end
  end

  assign result_lo = acc[DATA_W-1:0];
  assign result_hi = acc[2*DATA_W-1:DATA_W];

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative unsigned MUL/MULHU/DIVU/REMU with write-back handshake
module muldiv_unit
  import muldiv_pkg::*;
(
  input logic          clk,
  input logic          reset,
  muldiv_unit_if.slave bus
);

  state_t            state;
  logic [CNT_W-1:0]  count;
  opCode_t           opReg;
  logic [REG_AW-1:0] rdReg;
  logic              wbValid;
  logic [REG_AW-1:0] wbReg;
  logic              accept;
  logic              lastIter;
  logic [DATA_W-1:0] resultLo;
  logic [DATA_W-1:0] resultHi;

  // flush blocks acceptance even in IDLE
  assign accept   = (state == IDLE) && bus.start_valid && !bus.flush;
  assign lastIter = (count == CNT_W'(DATA_W - 1));

  muldiv_datapath u_datapath (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .step      (state == BUSY),
    .op        (bus.op),
    .opA       (bus.rs1_data),
    .opB       (bus.rs2_data),
    .result_lo (resultLo),
    .result_hi (resultHi)
  );

  // Control FSM: flush outranks both completion and the write-back handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      opReg   <= OP_MUL;
      rdReg   <= '0;
      wbValid <= 1'b0;
      wbReg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            opReg <= bus.op;
            rdReg <= bus.rd;
            count <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (bus.flush) begin
            state <= IDLE;
          end else if (lastIter) begin
            // Writes to x0 are dropped without ever raising wb_valid
            if (rdReg != '0) begin
              state   <= DONE;
              wbValid <= 1'b1;
              wbReg   <= rdReg;
            end else begin
              state <= IDLE;
            end
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        DONE: begin
          if (bus.flush || bus.wb_ready) begin
            state   <= IDLE;
            wbValid <= 1'b0;
            wbReg   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.start_ready = (state == IDLE);
  assign bus.busy        = (state != IDLE);
  assign bus.busy_rd     = (state == IDLE) ? '0 : rdReg;
  assign bus.wb_valid    = wbValid;
  assign bus.wb_reg      = wbReg;
  // The accumulator is frozen outside BUSY, so this is stable for the whole DONE period
  assign bus.wb_data     = wbValid ? (selectsHigh(opReg) ? resultHi : resultLo) : '0;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed and random checks of muldiv_unit against an arithmetic model
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  muldiv_unit_if bus ();

  muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] refModel(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    case (o)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, wait (bounded) for wb_valid, then complete the handshake after 'stall' low cycles
  task automatic runOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] r, input int stall,
                       output logic [31:0] data, output logic [4:0] wbr, output int lat);
    bus.op          = opCode_t'(o);
    bus.rs1_data    = a;
    bus.rs2_data    = b;
    bus.rd          = r;
    bus.start_valid = 1'b1;
    bus.wb_ready    = (stall == 0);
    tick();
    bus.start_valid = 1'b0;
    lat = 0;
    while (!bus.wb_valid && lat < 40) begin
      tick();
      lat++;
    end
    data = bus.wb_data;
    wbr  = bus.wb_reg;
    repeat (stall) tick();
    bus.wb_ready = 1'b1;
    tick();
  endtask

  logic [31:0] data, held, expv, a, b;
  logic [4:0]  wbr, r;
  logic [1:0]  o;
  int          lat, seen, busyCount, stall;

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.start_valid = 1'b0;
    bus.op          = OP_MUL;
    bus.rs1_data    = '0;
    bus.rs2_data    = '0;
    bus.rd          = '0;
    bus.flush       = 1'b0;
    bus.wb_ready    = 1'b1;
    #12;
    reset = 1'b0;
    #1;
    check("rst_start_ready", bus.start_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_busy_rd", bus.busy_rd, 0);
    check("rst_wb_valid", bus.wb_valid, 0);
    check("rst_wb_reg", bus.wb_reg, 0);
    check("rst_wb_data", bus.wb_data, 0);
    tick();

    // MUL 7*6 -> x3, latency and start_ready timing
    bus.op = OP_MUL; bus.rs1_data = 7; bus.rs2_data = 6; bus.rd = 3;
    bus.start_valid = 1'b1; bus.wb_ready = 1'b1;
    tick();
    bus.start_valid = 1'b0;
    check("mul_busy", bus.busy, 1);
    check("mul_busy_rd", bus.busy_rd, 3);
    check("mul_start_ready_busy", bus.start_ready, 0);
    lat = 0;
    while (!bus.wb_valid && lat < 40) begin tick(); lat++; end
    check("mul_latency", lat, 32);
    check("mul_wb_reg", bus.wb_reg, 3);
    check("mul_wb_data", bus.wb_data, 32'h2A);
    check("mul_start_ready_done", bus.start_ready, 0);
    tick();
    check("mul_start_ready_after", bus.start_ready, 1);
    check("mul_wb_valid_after", bus.wb_valid, 0);

    // Directed arithmetic corners
    runOp(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 0, data, wbr, lat);
    check("mul_ff", data, 32'h0000_0001);
    runOp(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0, data, wbr, lat);
    check("mulhu_ff", data, 32'hFFFF_FFFE);
    runOp(2'd2, 100, 7, 5'd4, 0, data, wbr, lat);
    check("divu_100_7", data, 14);
    runOp(2'd3, 100, 7, 5'd5, 0, data, wbr, lat);
    check("remu_100_7", data, 2);
    runOp(2'd2, 32'h1234, 0, 5'd6, 0, data, wbr, lat);
    check("divu_by0", data, 32'hFFFF_FFFF);
    runOp(2'd3, 32'h1234, 0, 5'd7, 0, data, wbr, lat);
    check("remu_by0", data, 32'h0000_1234);
    check("remu_by0_wb_reg", wbr, 7);

    // Write-back back-pressure with start_valid held high throughout
    bus.op = OP_MUL; bus.rs1_data = 32'h0001_0000; bus.rs2_data = 3; bus.rd = 9;
    bus.start_valid = 1'b1; bus.wb_ready = 1'b0;
    tick();
    lat = 0;
    while (!bus.wb_valid && lat < 40) begin tick(); lat++; end
    check("stall_latency", lat, 32);
    held = bus.wb_data;
    check("stall_data", held, 32'h0003_0000);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_wb_valid", bus.wb_valid, 1);
      check("stall_wb_data_stable", bus.wb_data, held);
      check("stall_start_ready", bus.start_ready, 0);
    end
    bus.wb_ready = 1'b1;
    tick();
    check("stall_release_wb_valid", bus.wb_valid, 0);
    check("stall_release_busy", bus.busy, 0);
    check("stall_release_start_ready", bus.start_ready, 1);
    bus.start_valid = 1'b0;

    // Asynchronous reset at iteration 10 of a DIVU
    bus.op = OP_DIVU; bus.rs1_data = 1000; bus.rs2_data = 3; bus.rd = 8;
    bus.start_valid = 1'b1;
    tick();
    bus.start_valid = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    #1;
    check("areset_busy", bus.busy, 0);
    check("areset_start_ready", bus.start_ready, 1);
    check("areset_busy_rd", bus.busy_rd, 0);
    check("areset_wb_valid", bus.wb_valid, 0);
    #2;
    reset = 1'b0;
    tick();
    runOp(2'd2, 9, 3, 5'd10, 0, data, wbr, lat);
    check("after_reset_divu", data, 3);
    check("after_reset_latency", lat, 32);

    // Flush at iteration 10 of a DIVU
    bus.op = OP_DIVU; bus.rs1_data = 1000; bus.rs2_data = 3; bus.rd = 11;
    bus.start_valid = 1'b1;
    tick();
    bus.start_valid = 1'b0;
    repeat (10) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_busy", bus.busy, 0);
    check("flush_busy_rd", bus.busy_rd, 0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.wb_valid) seen++;
      tick();
    end
    check("flush_no_wb_valid", seen, 0);
    runOp(2'd2, 9, 3, 5'd12, 0, data, wbr, lat);
    check("after_flush_divu", data, 3);

    // Flush while done discards the pending result
    runOp(2'd0, 5, 5, 5'd13, 0, data, wbr, lat);
    bus.op = OP_MUL; bus.rs1_data = 2; bus.rs2_data = 2; bus.rd = 14;
    bus.start_valid = 1'b1; bus.wb_ready = 1'b0;
    tick();
    bus.start_valid = 1'b0;
    lat = 0;
    while (!bus.wb_valid && lat < 40) begin tick(); lat++; end
    bus.flush = 1'b1; bus.wb_ready = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_done_wb_valid", bus.wb_valid, 0);
    check("flush_done_wb_data", bus.wb_data, 0);
    check("flush_done_busy", bus.busy, 0);

    // rd = 0: full run, no write-back
    bus.op = OP_MUL; bus.rs1_data = 5; bus.rs2_data = 5; bus.rd = 0;
    bus.start_valid = 1'b1;
    tick();
    bus.start_valid = 1'b0;
    busyCount = 0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.busy) busyCount++;
      if (bus.wb_valid) seen++;
      tick();
    end
    check("rd0_busy_cycles", busyCount, 32);
    check("rd0_no_wb_valid", seen, 0);
    check("rd0_start_ready", bus.start_ready, 1);

    // flush and start_valid together in IDLE: nothing accepted
    bus.rd = 15; bus.start_valid = 1'b1; bus.flush = 1'b1;
    tick();
    bus.start_valid = 1'b0; bus.flush = 1'b0;
    check("idle_flush_start_busy", bus.busy, 0);

    // Random operations with random write-back stalls
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      r = 5'($urandom_range(1, 31));
      stall = $urandom_range(0, 3);
      expv = refModel(o, a, b);
      runOp(o, a, b, r, stall, data, wbr, lat);
      check($sformatf("rand%0d_op%0d_data", i, o), data, expv);
      check($sformatf("rand%0d_wb_reg", i), wbr, r);
      check($sformatf("rand%0d_latency", i), lat, 32);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
